// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter and related bus arbiters.
package uart_arb_pkg;

  // Arbiter FSM states; the numeric encoding is fixed so it can be
  // observed and decoded on a debug bus.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_e;

  localparam int ARB_STATE_W = 2;

  // Index width for a requester vector; never returns zero, so a
  // two-requester arbiter still gets a one-bit pointer.
  function automatic int clog2_safe(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: finds the first set request bit
// starting at rr_ptr_i and wrapping modulo NUM_REQ.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2_safe(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Walk the requesters in priority order beginning at the pointer; the
  // wrap is done by subtraction so non-power-of-two counts work too.
  always_comb begin
    int             cand;
    logic [IDX_W-1:0] cand_idx;
    logic           found;
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    found    = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(rr_ptr_i) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found = 1'b1;
        idx_o = cand_idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among several byte producers: round-robin grant,
// byte latch, one-cycle send strobe, completion ack and a watchdog that
// frees the transmitter if tx_done never arrives.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 30000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic [NUM_REQ-1:0]           ack_o,
  output logic                         err_o,
  output logic                         send_sig_o,
  output logic [DATA_LEN-1:0]          tx_byte_o,
  input  logic                         tx_busy_i,
  input  logic                         tx_done_i
);

  localparam int IDX_W = clog2_safe(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  arb_state_e state_q, state_d;

  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic                send_q, send_d;
  logic [DATA_LEN-1:0] tx_byte_q, tx_byte_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    next_ptr;
  logic [DATA_LEN-1:0] req_bytes [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i    (req_i),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  // Split the flat requester data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data_i[i*DATA_LEN +: DATA_LEN];
    end
  end

  // Pointer just past the current owner, so it drops to lowest priority.
  assign next_ptr = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ack_d     = '0;
    err_d     = 1'b0;
    send_d    = 1'b0;
    tx_byte_d = tx_byte_q;
    rr_ptr_d  = rr_ptr_q;
    idx_d     = idx_q;
    wd_cnt_d  = wd_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d   = ONE_HOT0 << pick_idx;
          tx_byte_d = req_bytes[pick_idx];
          idx_d     = pick_idx;
          wd_cnt_d  = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!tx_busy_i) begin
          send_d  = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (tx_done_i) begin
          ack_d    = ONE_HOT0 << idx_q;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = RELEASE;
        end else if (wd_cnt_q == WD_LIMIT) begin
          err_d    = 1'b1;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      send_q    <= 1'b0;
      tx_byte_q <= '0;
      rr_ptr_q  <= '0;
      idx_q     <= '0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      send_q    <= send_d;
      tx_byte_q <= tx_byte_d;
      rr_ptr_q  <= rr_ptr_d;
      idx_q     <= idx_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  assign grant_o    = grant_q;
  assign ack_o      = ack_q;
  assign err_o      = err_q;
  assign send_sig_o = send_q;
  assign tx_byte_o  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural uart_tx
// (4 clocks per bit) driving tx_busy/tx_done and a serial line.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        err;
  logic        send_sig;
  logic [7:0]  tx_byte;
  logic        tx_busy;
  logic        tx_done;

  logic        force_busy;
  logic        suppress_done;
  logic        inject_done;

  logic        m_busy;
  logic        m_done;
  logic        m_serial;
  logic [9:0]  m_frame;
  logic [3:0]  m_bit;
  logic [1:0]  m_cnt;

  int n_compared;
  int n_mismatched;

  assign tx_busy = m_busy | force_busy;
  assign tx_done = (m_done & ~suppress_done) | inject_done;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .DATA_LEN       (8),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req),
    .req_data_i (req_data),
    .grant_o    (grant),
    .ack_o      (ack),
    .err_o      (err),
    .send_sig_o (send_sig),
    .tx_byte_o  (tx_byte),
    .tx_busy_i  (tx_busy),
    .tx_done_i  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural transmitter: start bit, 8 data bits LSB first, stop bit,
  // then a one-cycle done pulse.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_serial <= 1'b1;
      m_frame  <= '0;
      m_bit    <= '0;
      m_cnt    <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (send_sig) begin
          m_frame  <= {1'b1, tx_byte, 1'b0};
          m_busy   <= 1'b1;
          m_bit    <= '0;
          m_cnt    <= '0;
          m_serial <= 1'b0;
        end
      end else if (m_cnt == 2'd3) begin
        m_cnt <= '0;
        if (m_bit == 4'd9) begin
          m_busy   <= 1'b0;
          m_done   <= 1'b1;
          m_serial <= 1'b1;
        end else begin
          m_bit    <= m_bit + 4'd1;
          m_serial <= m_frame[m_bit + 4'd1];
        end
      end else begin
        m_cnt <= m_cnt + 2'd1;
      end
    end
  end

  task automatic do_reset();
    req           = '0;
    req_data      = '0;
    force_busy    = 1'b0;
    suppress_done = 1'b0;
    inject_done   = 1'b0;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Called at the negedge where send_sig is first seen; samples mid-bit.
  task automatic receive_frame(output logic [9:0] bits);
    repeat (2) @(negedge clk);
    bits[0] = m_serial;
    for (int k = 1; k < 10; k++) begin
      repeat (4) @(negedge clk);
      bits[k] = m_serial;
    end
  endtask

  task automatic wait_ack(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (ack != 4'd0) ok = 1'b1;
    end
  endtask

  task automatic wait_send(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (send_sig) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    req           = 4'b1111;
    req_data      = 32'hFFFF_FFFF;
    force_busy    = 1'b0;
    suppress_done = 1'b0;
    inject_done   = 1'b0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    n_compared++;
    if (grant !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_grant: got %b, expected 0000", grant); end
    n_compared++;
    if (ack !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_ack: got %b, expected 0000", ack); end
    n_compared++;
    if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_err: got %b, expected 0", err); end
    n_compared++;
    if (send_sig !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_send: got %b, expected 0", send_sig); end
    n_compared++;
    if (tx_byte !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_tx_byte: got %h, expected 00", tx_byte); end
  endtask

  task automatic test_single();
    logic [9:0] bits;
    logic       seen;
    do_reset();
    req_data[15:8] = 8'hA5;
    req = 4'b0010;
    @(negedge clk);
    n_compared++;
    if (grant !== 4'b0010) begin n_mismatched++; $display("[TB] FAIL single_grant: got %b, expected 0010", grant); end
    n_compared++;
    if (send_sig !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_send_early: got %b, expected 0", send_sig); end
    @(negedge clk);
    n_compared++;
    if (send_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_send: got %b, expected 1", send_sig); end
    n_compared++;
    if (tx_byte !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL single_tx_byte: got %h, expected a5", tx_byte); end
    receive_frame(bits);
    n_compared++;
    if (bits !== 10'b1101001010) begin n_mismatched++; $display("[TB] FAIL single_serial: got %b, expected 1101001010", bits); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_done) seen = 1'b1;
    end
    n_compared++;
    if (seen !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_done_wait: got %b, expected 1", seen); end
    n_compared++;
    if (ack !== 4'd0) begin n_mismatched++; $display("[TB] FAIL single_ack_early: got %b, expected 0000", ack); end
    @(negedge clk);
    n_compared++;
    if (ack !== 4'b0010) begin n_mismatched++; $display("[TB] FAIL single_ack: got %b, expected 0010", ack); end
    n_compared++;
    if (grant !== 4'd0) begin n_mismatched++; $display("[TB] FAIL single_grant_release: got %b, expected 0000", grant); end
    req = 4'd0;
    @(negedge clk);
    n_compared++;
    if (ack !== 4'd0) begin n_mismatched++; $display("[TB] FAIL single_ack_pulse: got %b, expected 0000", ack); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_order [5];
    logic [3:0] order [5];
    logic [3:0] prev_grant;
    logic [7:0] ebyte;
    logic       multi, ack_bad, byte_bad, gap_bad, err_seen;
    int         nacks, ngrants, last_ack_cyc;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    order     = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    do_reset();
    req_data = 32'h4433_2211;
    req      = 4'b1111;
    prev_grant = '0;
    multi = 0; ack_bad = 0; byte_bad = 0; gap_bad = 0; err_seen = 0;
    nacks = 0; ngrants = 0; last_ack_cyc = 0;
    for (int cyc = 1; cyc <= 1000 && nacks < 5; cyc++) begin
      @(negedge clk);
      if ((grant & (grant - 4'd1)) != 4'd0) multi = 1'b1;
      if (grant != 4'd0 && prev_grant == 4'd0) begin
        if (ngrants < 5) order[ngrants] = grant;
        ebyte = 8'h00;
        for (int i = 0; i < 4; i++) if (grant[i]) ebyte = 8'(8'h11 * (i + 1));
        if (tx_byte !== ebyte) byte_bad = 1'b1;
        if (nacks > 0 && cyc - last_ack_cyc != 2) gap_bad = 1'b1;
        ngrants++;
      end
      if (ack != 4'd0) begin
        if (ack !== prev_grant) ack_bad = 1'b1;
        nacks++;
        last_ack_cyc = cyc;
      end
      if (err) err_seen = 1'b1;
      prev_grant = grant;
    end
    req = 4'd0;
    n_compared++;
    if (nacks != 5) begin n_mismatched++; $display("[TB] FAIL rr_ack_count: got %0d, expected 5", nacks); end
    for (int i = 0; i < 5; i++) begin
      n_compared++;
      if (order[i] !== exp_order[i]) begin n_mismatched++; $display("[TB] FAIL rr_order_%0d: got %b, expected %b", i, order[i], exp_order[i]); end
    end
    n_compared++;
    if (multi !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rr_multi_hot: got %b, expected 0", multi); end
    n_compared++;
    if (ack_bad !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rr_ack_target: got %b, expected 0", ack_bad); end
    n_compared++;
    if (byte_bad !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rr_tx_byte: got %b, expected 0", byte_bad); end
    n_compared++;
    if (gap_bad !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rr_ack_to_grant: got %b, expected 0", gap_bad); end
    n_compared++;
    if (err_seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rr_err: got %b, expected 0", err_seen); end
  endtask

  task automatic test_watchdog();
    int   cnt;
    logic ack_seen, ok;
    do_reset();
    suppress_done   = 1'b1;
    req_data[23:16] = 8'h5A;
    req_data[31:24] = 8'hC3;
    req = 4'b0100;
    @(negedge clk);
    n_compared++;
    if (grant !== 4'b0100) begin n_mismatched++; $display("[TB] FAIL wd_grant: got %b, expected 0100", grant); end
    req = 4'b1001;
    @(negedge clk);
    n_compared++;
    if (send_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wd_send: got %b, expected 1", send_sig); end
    cnt = 0;
    ack_seen = 1'b0;
    do begin
      @(negedge clk);
      cnt++;
      if (ack != 4'd0) ack_seen = 1'b1;
    end while (!err && cnt < 200);
    n_compared++;
    if (cnt != 50) begin n_mismatched++; $display("[TB] FAIL wd_err_latency: got %0d, expected 50", cnt); end
    n_compared++;
    if (grant !== 4'd0) begin n_mismatched++; $display("[TB] FAIL wd_grant_release: got %b, expected 0000", grant); end
    n_compared++;
    if (ack_seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wd_no_ack: got %b, expected 0", ack_seen); end
    @(negedge clk);
    n_compared++;
    if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wd_err_pulse: got %b, expected 0", err); end
    @(negedge clk);
    n_compared++;
    if (grant !== 4'b1000) begin n_mismatched++; $display("[TB] FAIL wd_next_grant: got %b, expected 1000", grant); end
    suppress_done = 1'b0;
    wait_ack(ok);
    n_compared++;
    if (ok !== 1'b1 || ack !== 4'b1000) begin n_mismatched++; $display("[TB] FAIL wd_next_ack: got %b, expected 1000", ack); end
    req = 4'd0;
  endtask

  task automatic test_done_vs_timeout();
    logic err_seen;
    do_reset();
    suppress_done  = 1'b1;
    req_data[7:0]  = 8'h77;
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    n_compared++;
    if (send_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL tie_send: got %b, expected 1", send_sig); end
    repeat (49) @(negedge clk);
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    n_compared++;
    if (ack !== 4'b0001) begin n_mismatched++; $display("[TB] FAIL tie_ack: got %b, expected 0001", ack); end
    err_seen = err;
    req = 4'd0;
    repeat (3) begin
      @(negedge clk);
      if (err) err_seen = 1'b1;
    end
    n_compared++;
    if (err_seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL tie_no_err: got %b, expected 0", err_seen); end
    suppress_done = 1'b0;
  endtask

  task automatic test_busy_hold();
    logic early, ok;
    do_reset();
    force_busy    = 1'b1;
    req_data[7:0] = 8'h81;
    req = 4'b0001;
    @(negedge clk);
    n_compared++;
    if (grant !== 4'b0001) begin n_mismatched++; $display("[TB] FAIL busy_grant: got %b, expected 0001", grant); end
    early = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (send_sig) early = 1'b1;
    end
    n_compared++;
    if (early !== 1'b0) begin n_mismatched++; $display("[TB] FAIL busy_hold_send: got %b, expected 0", early); end
    force_busy = 1'b0;
    @(negedge clk);
    n_compared++;
    if (send_sig !== 1'b1) begin n_mismatched++; $display("[TB] FAIL busy_release_send: got %b, expected 1", send_sig); end
    wait_ack(ok);
    n_compared++;
    if (ok !== 1'b1 || ack !== 4'b0001) begin n_mismatched++; $display("[TB] FAIL busy_ack: got %b, expected 0001", ack); end
    req = 4'd0;
  endtask

  task automatic test_req_drop();
    logic [9:0] bits;
    logic       ok;
    do_reset();
    req_data[15:8] = 8'h3C;
    req = 4'b0010;
    @(negedge clk);
    n_compared++;
    if (grant !== 4'b0010) begin n_mismatched++; $display("[TB] FAIL drop_grant: got %b, expected 0010", grant); end
    req      = 4'd0;
    req_data = 32'd0;
    @(negedge clk);
    n_compared++;
    if (send_sig !== 1'b1 || tx_byte !== 8'h3C) begin n_mismatched++; $display("[TB] FAIL drop_send_byte: got %b/%h, expected 1/3c", send_sig, tx_byte); end
    receive_frame(bits);
    n_compared++;
    if (bits !== 10'b1001111000) begin n_mismatched++; $display("[TB] FAIL drop_serial: got %b, expected 1001111000", bits); end
    wait_ack(ok);
    n_compared++;
    if (ok !== 1'b1 || ack !== 4'b0010) begin n_mismatched++; $display("[TB] FAIL drop_ack: got %b, expected 0010", ack); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    do_reset();
    req_data[23:16] = 8'h99;
    req = 4'b0100;
    wait_ack(ok);
    n_compared++;
    if (ok !== 1'b1 || ack !== 4'b0100) begin n_mismatched++; $display("[TB] FAIL mid_first_ack: got %b, expected 0100", ack); end
    req = 4'd0;
    @(negedge clk);
    req = 4'b0100;
    wait_send(ok);
    n_compared++;
    if (ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_send_wait: got %b, expected 1", ok); end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    n_compared++;
    if ({grant, ack, err, send_sig} !== 10'd0) begin n_mismatched++; $display("[TB] FAIL mid_reset_ctrl: got %b, expected 0", {grant, ack, err, send_sig}); end
    n_compared++;
    if (tx_byte !== 8'h00) begin n_mismatched++; $display("[TB] FAIL mid_reset_tx_byte: got %h, expected 00", tx_byte); end
    req = 4'b1001;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_compared++;
    if (grant !== 4'b0001) begin n_mismatched++; $display("[TB] FAIL mid_first_grant: got %b, expected 0001", grant); end
    req = 4'd0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b1;
    req          = '0;
    req_data     = '0;
    force_busy    = 1'b0;
    suppress_done = 1'b0;
    inject_done   = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_watchdog();
    test_done_vs_timeout();
    test_busy_hold();
    test_req_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
